// File: rtl/adf_spi_capture.sv
// Receive-side ADF4351 three-wire deserializer: captures 32-bit words on LE rise into an R0..R5 shadow.
// Optional macro ADF_FIELD_DECODE_EN adds registered INT/FRAC/MOD field outputs.
module adf_spi_capture (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ADF_CLK,
    input  logic        ADF_DATA,
    input  logic        ADF_LE,
    output logic [31:0] WORD,
    output logic        WORD_VALID,
    output logic [31:0] R0,
    output logic [31:0] R1,
    output logic [31:0] R2,
    output logic [31:0] R3,
    output logic [31:0] R4,
    output logic [31:0] R5,
    output logic [5:0]  WRITTEN,
    output logic        CFG_DONE,
    output logic        LEN_ERR,
`ifdef ADF_FIELD_DECODE_EN
    output logic        ADDR_ERR,
    output logic [15:0] INT_VAL,
    output logic [11:0] FRAC_VAL,
    output logic [11:0] MOD_VAL
`else
    output logic        ADDR_ERR
`endif
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned NUM_REGS = 6;
    localparam int unsigned CTRL_W   = 3;

    logic sclk_s1, sclk_s2, sclk_prev;
    logic data_s1, data_s2;
    logic le_s1, le_s2, le_prev;

    // Edge strobes and the data bit that belongs to the clock edge, one stage after detection
    logic sclk_rise_q;
    logic le_rise_q;
    logic data_q;

    logic [WORD_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shadow [NUM_REGS];

    logic [CTRL_W-1:0] ctrl_c;
    logic              len_ok_c;
    logic              addr_ok_c;
    logic              cfg_hit_c;

    // Word qualification from the current shift contents and bit count
    always_comb begin
        ctrl_c    = shift_reg[CTRL_W-1:0];
        len_ok_c  = 1'b0;
        addr_ok_c = 1'b0;
        cfg_hit_c = 1'b0;
        if (bit_cnt == CNT_W'(WORD_W)) begin
            len_ok_c = 1'b1;
        end
        if (ctrl_c <= CTRL_W'(NUM_REGS - 1)) begin
            addr_ok_c = 1'b1;
        end
        if ((ctrl_c == '0) && (&WRITTEN[NUM_REGS-1:1])) begin
            cfg_hit_c = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_s1     <= 1'b0;
            sclk_s2     <= 1'b0;
            sclk_prev   <= 1'b0;
            data_s1     <= 1'b0;
            data_s2     <= 1'b0;
            le_s1       <= 1'b0;
            le_s2       <= 1'b0;
            le_prev     <= 1'b0;
            sclk_rise_q <= 1'b0;
            le_rise_q   <= 1'b0;
            data_q      <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            WORD        <= '0;
            WORD_VALID  <= 1'b0;
            WRITTEN     <= '0;
            CFG_DONE    <= 1'b0;
            LEN_ERR     <= 1'b0;
            ADDR_ERR    <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                shadow[i] <= '0;
            end
        end else begin
            sclk_s1   <= ADF_CLK;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            data_s1   <= ADF_DATA;
            data_s2   <= data_s1;
            le_s1     <= ADF_LE;
            le_s2     <= le_s1;
            le_prev   <= le_s2;

            // LE level (including its own rising edge) suppresses serial clock edges
            sclk_rise_q <= sclk_s2 & ~sclk_prev & ~le_s2;
            le_rise_q   <= le_s2 & ~le_prev;
            data_q      <= data_s2;

            WORD_VALID <= 1'b0;
            LEN_ERR    <= 1'b0;
            ADDR_ERR   <= 1'b0;

            if (le_rise_q) begin
                bit_cnt <= '0;
                if (len_ok_c) begin
                    WORD       <= shift_reg;
                    WORD_VALID <= 1'b1;
                    if (addr_ok_c) begin
                        for (int i = 0; i < int'(NUM_REGS); i++) begin
                            if (ctrl_c == CTRL_W'(i)) begin
                                shadow[i]  <= shift_reg;
                                WRITTEN[i] <= 1'b1;
                            end
                        end
                        if (cfg_hit_c) begin
                            CFG_DONE <= 1'b1;
                        end
                    end else begin
                        ADDR_ERR <= 1'b1;
                    end
                end else begin
                    LEN_ERR <= 1'b1;
                end
            end else if (sclk_rise_q) begin
                shift_reg <= {shift_reg[WORD_W-2:0], data_q};
                if (bit_cnt != '1) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign R0 = shadow[0];
    assign R1 = shadow[1];
    assign R2 = shadow[2];
    assign R3 = shadow[3];
    assign R4 = shadow[4];
    assign R5 = shadow[5];

`ifdef ADF_FIELD_DECODE_EN
    // Field views trail the shadow by one cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            INT_VAL  <= '0;
            FRAC_VAL <= '0;
            MOD_VAL  <= '0;
        end else begin
            INT_VAL  <= shadow[0][30:15];
            FRAC_VAL <= shadow[0][14:3];
            MOD_VAL  <= shadow[1][14:3];
        end
    end
`endif

endmodule
